sonar_escalonador: RTL and testbench

- Round-robin scheduler that shares one ultrasonic interface (trigger/echo/timeout FSM with medir/pronto handshake) among N_SENSORES muxed sensors.
- Selects a sensor, pulses medir, and waits for pronto under a watchdog.
- Captures the distance and tags it with the sensor id, or flags a failure and resets the interface.
- Enforces a minimum start-to-start interval; sits between the system top FSM and the interface.

---
 rtl/sonar_escalonador.sv | 137 +++++++++++++
 tb/tb_sonar_escalonador.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sonar_escalonador.sv
// sonar_escalonador: round-robin scheduler sharing one ultrasonic interface
// among N_SENSORES muxed sensors. Pulses medir, waits for pronto under a
// watchdog, tags results with the sensor id and enforces a minimum
// start-to-start interval between measurements.
// Optional: define ESCALONADOR_CONTA_FALHAS_EN to add the 8-bit saturating
// failure counter output 'falhas'.
module sonar_escalonador #(
  parameter int unsigned N_SENSORES = 4,
  parameter int unsigned SELW       = 2,
  parameter int unsigned W          = 12,
  parameter int unsigned INTERVALO  = 3000000,
  parameter int unsigned TIMEOUT    = 2500000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ligar,
  input  logic            pronto_sensor,
  input  logic [W-1:0]    medida,
  output logic            medir,
  output logic            reset_sensor,
  output logic [SELW-1:0] sel,
  output logic [W-1:0]    dado,
  output logic [SELW-1:0] dado_id,
  output logic            dado_valido,
  output logic            erro,
  output logic [SELW-1:0] erro_id,
  output logic            ocupado,
  output logic [3:0]      db_estado
`ifdef ESCALONADOR_CONTA_FALHAS_EN
  ,
  output logic [7:0]      falhas
`endif
);

  localparam int unsigned INT_W = (INTERVALO > 1) ? $clog2(INTERVALO) : 1;
  localparam int unsigned WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [INT_W-1:0] INT_MAX  = INT_W'(INTERVALO - 1);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT - 1);
  localparam logic [SELW-1:0]  SEL_LAST = SELW'(N_SENSORES - 1);

  typedef enum logic [3:0] {
    OCIOSO           = 4'b0000,
    DISPARA          = 4'b0001,
    AGUARDA          = 4'b0010,
    REGISTRA         = 4'b0011,
    FALHA            = 4'b0100,
    PROXIMO          = 4'b0101,
    ESPERA_INTERVALO = 4'b0110,
    ILEGAL           = 4'b1110
  } estado_t;

  estado_t           estado;
  logic [INT_W-1:0]  cnt_intervalo;
  logic [WD_W-1:0]   cnt_watchdog;

  // Scheduler FSM with interval counter, watchdog and captured result registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado        <= OCIOSO;
      cnt_intervalo <= '0;
      cnt_watchdog  <= '0;
      sel           <= '0;
      dado          <= '0;
      dado_id       <= '0;
      erro_id       <= '0;
    end else begin
      // Interval counter runs outside ocioso and saturates; clears below override
      if (estado != OCIOSO && cnt_intervalo != INT_MAX)
        cnt_intervalo <= cnt_intervalo + INT_W'(1);

      case (estado)
        OCIOSO: begin
          if (ligar) begin
            estado        <= DISPARA;
            cnt_intervalo <= '0;
            cnt_watchdog  <= '0;
          end
        end
        DISPARA: begin
          estado       <= AGUARDA;
          cnt_watchdog <= '0;
        end
        AGUARDA: begin
          if (cnt_watchdog != WD_MAX)
            cnt_watchdog <= cnt_watchdog + WD_W'(1);
          // pronto takes priority over a coincident watchdog expiry
          if (pronto_sensor) begin
            estado  <= REGISTRA;
            dado    <= medida;
            dado_id <= sel;
          end else if (cnt_watchdog == WD_MAX) begin
            estado  <= FALHA;
            erro_id <= sel;
          end
        end
        REGISTRA, FALHA: begin
          estado <= PROXIMO;
          sel    <= (sel == SEL_LAST) ? '0 : sel + SELW'(1);
        end
        PROXIMO: begin
          estado <= ESPERA_INTERVALO;
        end
        ESPERA_INTERVALO: begin
          if (!ligar) begin
            estado <= OCIOSO;
          end else if (cnt_intervalo == INT_MAX) begin
            estado        <= DISPARA;
            cnt_intervalo <= '0;
            cnt_watchdog  <= '0;
          end
        end
        default: begin
          estado <= OCIOSO;
        end
      endcase
    end
  end

`ifdef ESCALONADOR_CONTA_FALHAS_EN
  // Saturating count of watchdog failures since reset
  always_ff @(posedge clock) begin
    if (!reset)
      falhas <= '0;
    else if (estado == AGUARDA && !pronto_sensor && cnt_watchdog == WD_MAX && falhas != 8'hFF)
      falhas <= falhas + 8'd1;
  end
`endif

  // Moore control outputs decoded from the registered state
  assign medir        = (estado == DISPARA);
  assign dado_valido  = (estado == REGISTRA);
  assign erro         = (estado == FALHA);
  assign reset_sensor = (estado == FALHA);
  assign ocupado      = (estado != OCIOSO);
  assign db_estado    = estado;

endmodule

// File: tb/tb_sonar_escalonador.sv
// Directed bench for sonar_escalonador with N_SENSORES=3, INTERVALO=100,
// TIMEOUT=40. Inputs driven and outputs sampled on the falling edge.
module tb_sonar_escalonador;

  localparam int unsigned N_SENSORES = 3;
  localparam int unsigned SELW       = 2;
  localparam int unsigned W          = 12;
  localparam int unsigned INTERVALO  = 100;
  localparam int unsigned TIMEOUT    = 40;

  logic            clock = 1'b0;
  logic            reset;
  logic            ligar;
  logic            pronto_sensor;
  logic [W-1:0]    medida;
  logic            medir;
  logic            reset_sensor;
  logic [SELW-1:0] sel;
  logic [W-1:0]    dado;
  logic [SELW-1:0] dado_id;
  logic            dado_valido;
  logic            erro;
  logic [SELW-1:0] erro_id;
  logic            ocupado;
  logic [3:0]      db_estado;
`ifdef ESCALONADOR_CONTA_FALHAS_EN
  logic [7:0]      falhas;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0, t1, t2, t3;

  sonar_escalonador #(
    .N_SENSORES(N_SENSORES), .SELW(SELW), .W(W),
    .INTERVALO(INTERVALO), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset), .ligar(ligar),
    .pronto_sensor(pronto_sensor), .medida(medida),
    .medir(medir), .reset_sensor(reset_sensor), .sel(sel),
    .dado(dado), .dado_id(dado_id), .dado_valido(dado_valido),
    .erro(erro), .erro_id(erro_id), .ocupado(ocupado),
    .db_estado(db_estado)
`ifdef ESCALONADOR_CONTA_FALHAS_EN
    , .falhas(falhas)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Advance to the next medir pulse within a bounded number of cycles
  task automatic wait_medir(output int t, output bit found);
    found = 1'b0;
    t = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clock);
      if (medir === 1'b1) begin
        found = 1'b1;
        t = cyc;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; ligar = 1'b0; pronto_sensor = 1'b0; medida = '0;
    repeat (2) @(negedge clock);
    checks++; if (db_estado !== 4'h0) begin errors++; $display("FAIL reset_db: got %0h expected 0", db_estado); end
    checks++; if (medir !== 1'b0 || ocupado !== 1'b0 || erro !== 1'b0 || dado_valido !== 1'b0 || reset_sensor !== 1'b0) begin errors++; $display("FAIL reset_ctrl: got medir=%b ocupado=%b erro=%b valido=%b rs=%b expected all 0", medir, ocupado, erro, dado_valido, reset_sensor); end
    checks++; if (sel !== 2'd0 || dado !== 12'h000 || dado_id !== 2'd0 || erro_id !== 2'd0) begin errors++; $display("FAIL reset_data: got sel=%0h dado=%0h id=%0h eid=%0h expected 0", sel, dado, dado_id, erro_id); end
`ifdef ESCALONADOR_CONTA_FALHAS_EN
    checks++; if (falhas !== 8'd0) begin errors++; $display("FAIL reset_falhas: got %0d expected 0", falhas); end
`endif
    reset = 1'b1;
    @(negedge clock);
    checks++; if (db_estado !== 4'h0) begin errors++; $display("FAIL idle_db: got %0h expected 0", db_estado); end
  endtask

  task automatic test_first_measure();
    bit found;
    ligar = 1'b1;
    @(negedge clock);
    t0 = cyc;
    checks++; if (medir !== 1'b1 || db_estado !== 4'h1) begin errors++; $display("FAIL first_medir: got medir=%b db=%0h expected 1/1", medir, db_estado); end
    checks++; if (sel !== 2'd0 || ocupado !== 1'b1) begin errors++; $display("FAIL first_sel: got sel=%0h ocupado=%b expected 0/1", sel, ocupado); end
    @(negedge clock);
    checks++; if (medir !== 1'b0 || db_estado !== 4'h2) begin errors++; $display("FAIL first_aguarda: got medir=%b db=%0h expected 0/2", medir, db_estado); end
    repeat (19) @(negedge clock);
    pronto_sensor = 1'b1; medida = 12'h0A5;
    @(negedge clock);
    pronto_sensor = 1'b0; medida = 12'h000;
    checks++; if (dado_valido !== 1'b1 || db_estado !== 4'h3) begin errors++; $display("FAIL first_valido: got valido=%b db=%0h expected 1/3", dado_valido, db_estado); end
    checks++; if (dado !== 12'h0A5 || dado_id !== 2'd0 || erro !== 1'b0) begin errors++; $display("FAIL first_dado: got dado=%0h id=%0h erro=%b expected 0a5/0/0", dado, dado_id, erro); end
    @(negedge clock);
    checks++; if (sel !== 2'd1 || db_estado !== 4'h5 || dado_valido !== 1'b0) begin errors++; $display("FAIL first_proximo: got sel=%0h db=%0h valido=%b expected 1/5/0", sel, db_estado, dado_valido); end
    @(negedge clock);
    checks++; if (db_estado !== 4'h6) begin errors++; $display("FAIL first_espera: got %0h expected 6", db_estado); end
    wait_medir(t1, found);
    checks++; if (!found) begin errors++; $display("FAIL second_medir_timeout: got none expected medir"); end
    checks++; if (t1 - t0 !== 100) begin errors++; $display("FAIL interval_1: got %0d expected 100", t1 - t0); end
    checks++; if (sel !== 2'd1) begin errors++; $display("FAIL second_sel: got %0h expected 1", sel); end
  endtask

  task automatic test_falha();
    bit found = 1'b0;
    int te = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clock);
      if (erro === 1'b1) begin found = 1'b1; te = cyc; end
    end
    checks++; if (!found) begin errors++; $display("FAIL falha_timeout: got no erro expected erro"); end
    checks++; if (te - t1 !== 41) begin errors++; $display("FAIL falha_latency: got %0d expected 41", te - t1); end
    checks++; if (erro_id !== 2'd1 || reset_sensor !== 1'b1 || db_estado !== 4'h4) begin errors++; $display("FAIL falha_out: got eid=%0h rs=%b db=%0h expected 1/1/4", erro_id, reset_sensor, db_estado); end
    checks++; if (dado !== 12'h0A5 || dado_valido !== 1'b0) begin errors++; $display("FAIL falha_dado: got dado=%0h valido=%b expected 0a5/0", dado, dado_valido); end
`ifdef ESCALONADOR_CONTA_FALHAS_EN
    checks++; if (falhas !== 8'd1) begin errors++; $display("FAIL falha_count: got %0d expected 1", falhas); end
`endif
    @(negedge clock);
    checks++; if (erro !== 1'b0 || reset_sensor !== 1'b0 || sel !== 2'd2) begin errors++; $display("FAIL falha_after: got erro=%b rs=%b sel=%0h expected 0/0/2", erro, reset_sensor, sel); end
  endtask

  task automatic test_coincide_wrap();
    bit found;
    wait_medir(t2, found);
    checks++; if (!found || t2 - t1 !== 100) begin errors++; $display("FAIL interval_2: got found=%b dt=%0d expected 1/100", found, t2 - t1); end
    checks++; if (sel !== 2'd2) begin errors++; $display("FAIL third_sel: got %0h expected 2", sel); end
    repeat (40) @(negedge clock);
    pronto_sensor = 1'b1; medida = 12'h3C7;
    @(negedge clock);
    pronto_sensor = 1'b0; medida = 12'h000;
    checks++; if (dado_valido !== 1'b1 || erro !== 1'b0) begin errors++; $display("FAIL coincide: got valido=%b erro=%b expected 1/0", dado_valido, erro); end
    checks++; if (dado !== 12'h3C7 || dado_id !== 2'd2) begin errors++; $display("FAIL coincide_dado: got dado=%0h id=%0h expected 3c7/2", dado, dado_id); end
    @(negedge clock);
    checks++; if (sel !== 2'd0) begin errors++; $display("FAIL sel_wrap: got %0h expected 0", sel); end
    @(negedge clock);
    pronto_sensor = 1'b1; medida = 12'hFFF;
    @(negedge clock);
    pronto_sensor = 1'b0; medida = 12'h000;
    checks++; if (dado !== 12'h3C7 || dado_valido !== 1'b0 || db_estado !== 4'h6) begin errors++; $display("FAIL stray_pronto: got dado=%0h valido=%b db=%0h expected 3c7/0/6", dado, dado_valido, db_estado); end
  endtask

  task automatic test_ligar_off();
    bit found;
    int n_medir = 0;
    wait_medir(t3, found);
    checks++; if (!found || t3 - t2 !== 100) begin errors++; $display("FAIL interval_3: got found=%b dt=%0d expected 1/100", found, t3 - t2); end
    @(negedge clock);
    ligar = 1'b0;
    repeat (9) @(negedge clock);
    pronto_sensor = 1'b1; medida = 12'h055;
    @(negedge clock);
    pronto_sensor = 1'b0; medida = 12'h000;
    checks++; if (dado_valido !== 1'b1 || dado !== 12'h055 || dado_id !== 2'd0) begin errors++; $display("FAIL off_finish: got valido=%b dado=%0h id=%0h expected 1/055/0", dado_valido, dado, dado_id); end
    @(negedge clock);
    checks++; if (db_estado !== 4'h5 || sel !== 2'd1) begin errors++; $display("FAIL off_proximo: got db=%0h sel=%0h expected 5/1", db_estado, sel); end
    @(negedge clock);
    checks++; if (db_estado !== 4'h6 || ocupado !== 1'b1) begin errors++; $display("FAIL off_espera: got db=%0h ocupado=%b expected 6/1", db_estado, ocupado); end
    @(negedge clock);
    checks++; if (db_estado !== 4'h0 || ocupado !== 1'b0 || sel !== 2'd1) begin errors++; $display("FAIL off_ocioso: got db=%0h ocupado=%b sel=%0h expected 0/0/1", db_estado, ocupado, sel); end
    for (int i = 0; i < 150; i++) begin
      @(negedge clock);
      if (medir === 1'b1) n_medir++;
    end
    checks++; if (n_medir !== 0) begin errors++; $display("FAIL off_no_medir: got %0d pulses expected 0", n_medir); end
  endtask

  task automatic test_reset_mid();
    ligar = 1'b1;
    @(negedge clock);
    checks++; if (medir !== 1'b1 || sel !== 2'd1) begin errors++; $display("FAIL restart_medir: got medir=%b sel=%0h expected 1/1", medir, sel); end
    repeat (5) @(negedge clock);
    reset = 1'b0; ligar = 1'b0;
    @(negedge clock);
    checks++; if (db_estado !== 4'h0 || ocupado !== 1'b0 || medir !== 1'b0) begin errors++; $display("FAIL midreset_state: got db=%0h ocupado=%b medir=%b expected 0/0/0", db_estado, ocupado, medir); end
    checks++; if (sel !== 2'd0 || dado !== 12'h000 || dado_id !== 2'd0 || erro_id !== 2'd0) begin errors++; $display("FAIL midreset_data: got sel=%0h dado=%0h id=%0h eid=%0h expected 0", sel, dado, dado_id, erro_id); end
`ifdef ESCALONADOR_CONTA_FALHAS_EN
    checks++; if (falhas !== 8'd0) begin errors++; $display("FAIL midreset_falhas: got %0d expected 0", falhas); end
`endif
    reset = 1'b1; pronto_sensor = 1'b1; medida = 12'h777;
    @(negedge clock);
    pronto_sensor = 1'b0; medida = 12'h000;
    checks++; if (dado_valido !== 1'b0 || dado !== 12'h000 || db_estado !== 4'h0 || erro !== 1'b0) begin errors++; $display("FAIL late_pronto: got valido=%b dado=%0h db=%0h erro=%b expected 0/0/0/0", dado_valido, dado, db_estado, erro); end
  endtask

  initial begin
    test_reset();
    test_first_measure();
    test_falha();
    test_coincide_wrap();
    test_ligar_off();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
